stage_sequencer: RTL and testbench
==================================

Name: stage_sequencer

Overview:
- Multi-cycle control sequencer for the basic core.
- Generates `current_stage` and `current_instruction_type`, which drive the PC-update stage and the other per-stage datapath blocks.
- Walks each instruction through FETCH..WRITEBACK, stalls on the memory handshake, latches the fetched instruction type, and stops on a HALT instruction.
- Guarantees the final (PC-update) stage is presented for exactly one cycle per instruction, so the PC is written exactly once per instruction.

Parameters:
- NUM_STAGES, default `NUM_STAGES` (5), number of stages per instruction; must be >= 5.
- SW, default $clog2(NUM_STAGES), width of the stage index (derived; not overridden).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; begins execution from IDLE or HALTED.
- mem_ready  input  1  memory response/acknowledge for the current mem_req.
- fetched_instr_type  input  5  instruction type from the decoder; valid when mem_ready=1 in FETCH.
- current_stage  output  SW  stage index to the datapath (0=FETCH, 1=DECODE, 2=EXECUTE, 3=MEMORY, NUM_STAGES-1=WRITEBACK/PC update).
- current_instruction_type  output  5  latched type of the instruction in flight.
- mem_req  output  1  memory request; combinational from state, stage and type.
- running  output  1  high in RUN state.
- halted  output  1  high in HALTED state.
- retired_count  output  32  number of instructions completed since reset.

Behaviour:
- Control state: IDLE, RUN, HALTED (2-bit encoding). Stage counter SW bits.
- Reset (synchronous, rst=1 at a clk edge) has priority over everything and applies mid-operation. Values after reset:
  - state=IDLE, current_stage=0, current_instruction_type=INSTR_NOP (0), retired_count=0.
  - Outputs therefore: mem_req=0, running=0, halted=0.
- IDLE:
  - outputs held; start=1 -> RUN with current_stage=0 on the next cycle.
  - mem_ready ignored.
- RUN, stage FETCH (0):
  - mem_req=1.
  - mem_ready=0 -> hold stage (stall); no limit on stall length.
  - mem_ready=1 -> latch fetched_instr_type into current_instruction_type and advance to stage 1 on the same edge.
- RUN, stages DECODE and EXECUTE: advance unconditionally, 1 cycle each.
- RUN, stage MEMORY (3):
  - type is INSTR_LOAD or INSTR_STORE -> mem_req=1; advance only on mem_ready=1.
  - any other type -> mem_req=0; advance unconditionally.
- RUN, stages 4..NUM_STAGES-2: advance unconditionally.
- RUN, stage NUM_STAGES-1 (exactly one cycle):
  - retired_count increments by 1 (wraps modulo 2^32; HALT counts as retired).
  - type == INSTR_HALT -> state HALTED, current_stage=0.
  - otherwise current_stage wraps to 0 and stays in RUN.
- HALTED:
  - halted=1, mem_req=0; current_stage=0 and current_instruction_type are held.
  - start=1 -> RUN at FETCH; retired_count is not cleared.
- Ignored inputs:
  - start is ignored while in RUN.
  - mem_ready is ignored whenever mem_req=0.
- Latency without stalls: non-memory instruction = NUM_STAGES cycles; load/store with zero-wait memory = NUM_STAGES cycles. Each cycle of mem_ready=0 during a request adds one cycle.
- current_stage never skips a value and never exceeds NUM_STAGES-1.

Decomposition:
- Shared package (arch_defines.v):
  - stage index constants STAGE_FETCH, STAGE_DECODE, STAGE_EXECUTE, STAGE_MEMORY, STAGE_WRITEBACK (= NUM_STAGES-1).
  - instruction type codes INSTR_NOP, INSTR_LOAD, INSTR_STORE, INSTR_HALT.
  - sequencer state encodings SEQ_IDLE, SEQ_RUN, SEQ_HALTED.
- One sub-module: seq_stage_counter (wrapping stage counter with advance enable and synchronous clear).
- Remaining FSM and retired counter live in stage_sequencer.

Test Plan:
- Reset, then idle 5 cycles -> current_stage=0, running=0, halted=0, mem_req=0, retired_count=0 throughout.
- start pulse; mem_ready tied 1; feed 3 ALU-type instructions -> stage sequence 0,1,2,3,4 repeated; retired_count=3 after 15 cycles; mem_req low in stage 3.
- FETCH stall: mem_ready=0 for 3 cycles then 1 with type=INSTR_LOAD; MEMORY with mem_ready=0 for 2 cycles -> stage 0 held 4 cycles, stage 3 held 3 cycles; instruction takes 10 cycles; retired +1.
- INSTR_HALT fetched -> after stage 4, halted=1, current_stage=0, retired incremented; mem_req stays 0 with mem_ready toggling; start -> RUN resumes at FETCH with retired_count preserved.
- start pulsed during RUN at stage 2 -> no effect on stage sequence; rst asserted at stage 3 during a load stall -> next cycle IDLE, stage 0, type 0, retired_count=0.
- Wrap check: force retired_count near 32'hFFFF_FFFF (run from preload via hierarchical force) and retire one instruction -> retired_count=0.

Source files
------------

// File: rtl/stage_sequencer_pkg.sv
// Shared definitions for the multi-cycle stage sequencer: stage indices,
// instruction type codes and control-state encodings.
package stage_sequencer_pkg;

  localparam int unsigned NUM_STAGES_DEFAULT = 5;

  localparam int unsigned STAGE_FETCH   = 0;
  localparam int unsigned STAGE_DECODE  = 1;
  localparam int unsigned STAGE_EXECUTE = 2;
  localparam int unsigned STAGE_MEMORY  = 3;

  // Writeback/PC-update is always the last stage, whatever the pipeline depth.
  function automatic int unsigned stage_writeback(input int unsigned num_stages);
    return num_stages - 1;
  endfunction

  localparam logic [4:0] INSTR_NOP   = 5'd0;
  localparam logic [4:0] INSTR_LOAD  = 5'd1;
  localparam logic [4:0] INSTR_STORE = 5'd2;
  localparam logic [4:0] INSTR_HALT  = 5'd31;

  localparam logic [1:0] SEQ_IDLE   = 2'd0;
  localparam logic [1:0] SEQ_RUN    = 2'd1;
  localparam logic [1:0] SEQ_HALTED = 2'd2;

  function automatic logic is_mem_op(input logic [4:0] instr_type);
    return (instr_type == INSTR_LOAD) || (instr_type == INSTR_STORE);
  endfunction

endpackage

// File: rtl/seq_stage_counter.sv
// Wrapping stage counter: 0..NUM_STAGES-1 with advance enable and
// synchronous clear.
module seq_stage_counter
  import stage_sequencer_pkg::*;
#(
  parameter  int unsigned NUM_STAGES = NUM_STAGES_DEFAULT,
  localparam int unsigned SW         = $clog2(NUM_STAGES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          adv_i,
  output logic [SW-1:0] stage_o
);

  localparam logic [SW-1:0] LAST = SW'(stage_writeback(NUM_STAGES));

  logic [SW-1:0] stage_q, stage_d;

  always_comb begin
    stage_d = stage_q;
    if (clr_i) begin
      stage_d = '0;
    end else if (adv_i) begin
      stage_d = (stage_q == LAST) ? '0 : stage_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign stage_o = stage_q;

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle control sequencer: walks each instruction FETCH..WRITEBACK,
// stalls on the memory handshake and stops on HALT.
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter  int unsigned NUM_STAGES = NUM_STAGES_DEFAULT,
  localparam int unsigned SW         = $clog2(NUM_STAGES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mem_ready,
  input  logic [4:0]    fetched_instr_type,
  output logic [SW-1:0] current_stage,
  output logic [4:0]    current_instruction_type,
  output logic          mem_req,
  output logic          running,
  output logic          halted,
  output logic [31:0]   retired_count
);

  logic [1:0]  state_q, state_d;
  logic [4:0]  type_q, type_d;
  logic [31:0] retired_q, retired_d;
  logic        stage_adv, stage_clr;
  logic        at_fetch, at_memory, at_last, in_run;

  assign in_run    = (state_q == SEQ_RUN);
  assign at_fetch  = (current_stage == SW'(STAGE_FETCH));
  assign at_memory = (current_stage == SW'(STAGE_MEMORY));
  assign at_last   = (current_stage == SW'(stage_writeback(NUM_STAGES)));

  // A stage only waits when it is actually requesting memory; mem_ready is
  // don't-care otherwise.
  assign mem_req   = in_run && (at_fetch || (at_memory && is_mem_op(type_q)));
  assign stage_adv = in_run && (!mem_req || mem_ready);
  assign stage_clr = !in_run && start;

  seq_stage_counter #(
    .NUM_STAGES(NUM_STAGES)
  ) u_stage_counter (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (stage_clr),
    .adv_i  (stage_adv),
    .stage_o(current_stage)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      SEQ_IDLE:   if (start) state_d = SEQ_RUN;
      SEQ_RUN:    if (at_last && (type_q == INSTR_HALT)) state_d = SEQ_HALTED;
      SEQ_HALTED: if (start) state_d = SEQ_RUN;
      default:    state_d = SEQ_IDLE;
    endcase
  end

  always_comb begin
    type_d    = type_q;
    retired_d = retired_q;
    if (in_run && at_fetch && mem_ready) begin
      type_d = fetched_instr_type;
    end
    if (in_run && at_last) begin
      retired_d = retired_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SEQ_IDLE;
      type_q    <= INSTR_NOP;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      type_q    <= type_d;
      retired_q <= retired_d;
    end
  end

  assign current_instruction_type = type_q;
  assign retired_count            = retired_q;
  assign running                  = in_run;
  assign halted                   = (state_q == SEQ_HALTED);

endmodule

// File: tb/tb_stage_sequencer.sv
// Table-driven bench for stage_sequencer with an expected-value queue.
module tb_stage_sequencer;

  localparam logic [4:0] T_LOAD = 5'd1;
  localparam logic [4:0] T_HALT = 5'd31;

  logic        clk = 1'b0;
  logic        rst, start, mem_ready;
  logic [4:0]  fetched_instr_type;
  logic [2:0]  current_stage;
  logic [4:0]  current_instruction_type;
  logic        mem_req, running, halted;
  logic [31:0] retired_count;

  always #5 clk = ~clk;

  stage_sequencer #(.NUM_STAGES(5)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .start                   (start),
    .mem_ready               (mem_ready),
    .fetched_instr_type      (fetched_instr_type),
    .current_stage           (current_stage),
    .current_instruction_type(current_instruction_type),
    .mem_req                 (mem_req),
    .running                 (running),
    .halted                  (halted),
    .retired_count           (retired_count)
  );

  typedef struct {
    logic        rst, start, rdy;
    logic [4:0]  ft;
    logic [2:0]  st;
    logic [4:0]  ty;
    logic        req, run, hlt;
    logic [31:0] ret;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic r, s, m, input logic [4:0] f,
                              input logic [2:0] st, input logic [4:0] ty,
                              input logic rq, rn, h, input logic [31:0] rt);
    vec_t v;
    v.rst = r; v.start = s; v.rdy = m; v.ft = f;
    v.st = st; v.ty = ty; v.req = rq; v.run = rn; v.hlt = h; v.ret = rt;
    return v;
  endfunction

  task automatic add(input logic r, s, m, input logic [4:0] f,
                     input logic [2:0] st, input logic [4:0] ty,
                     input logic rq, rn, h, input logic [31:0] rt);
    vecs.push_back(mk(r, s, m, f, st, ty, rq, rn, h, rt));
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d actual=%0h required=%0h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle's inputs, then compare the outputs seen before the next edge.
  task automatic step(input vec_t v, input int idx);
    vec_t e;
    @(negedge clk);
    rst = v.rst; start = v.start; mem_ready = v.rdy; fetched_instr_type = v.ft;
    exp_q.push_back(v);
    #1;
    e = exp_q.pop_front();
    chk("stage",   idx, 32'(current_stage),            32'(e.st));
    chk("type",    idx, 32'(current_instruction_type), 32'(e.ty));
    chk("mem_req", idx, 32'(mem_req),                  32'(e.req));
    chk("running", idx, 32'(running),                  32'(e.run));
    chk("halted",  idx, 32'(halted),                   32'(e.hlt));
    chk("retired", idx, retired_count,                 e.ret);
    @(posedge clk);
  endtask

  initial begin
    logic [4:0] alu_t [3];
    logic [4:0] prev_t;
    alu_t[0] = 5'd3; alu_t[1] = 5'd4; alu_t[2] = 5'd6;

    rst = 1'b1; start = 1'b0; mem_ready = 1'b0; fetched_instr_type = '0;
    repeat (2) @(posedge clk);

    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 1'(i), 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    // three ALU instructions, zero-wait fetch
    prev_t = 5'd0;
    for (int k = 0; k < 3; k++) begin
      add(0, 0, 1, alu_t[k], 0, prev_t, 1, 1, 0, 32'(k));
      for (int s = 1; s < 5; s++) add(0, 0, 1, 0, 3'(s), alu_t[k], 0, 1, 0, 32'(k));
      prev_t = alu_t[k];
    end
    // load: 3-cycle fetch stall, 2-cycle memory stall
    for (int i = 0; i < 3; i++) add(0, 0, 0, T_LOAD, 0, 5'd6, 1, 1, 0, 3);
    add(0, 0, 1, T_LOAD, 0, 5'd6, 1, 1, 0, 3);
    add(0, 0, 1, 0, 1, T_LOAD, 0, 1, 0, 3);
    add(0, 0, 1, 0, 2, T_LOAD, 0, 1, 0, 3);
    add(0, 0, 0, 0, 3, T_LOAD, 1, 1, 0, 3);
    add(0, 0, 0, 0, 3, T_LOAD, 1, 1, 0, 3);
    add(0, 0, 1, 0, 3, T_LOAD, 1, 1, 0, 3);
    add(0, 0, 1, 0, 4, T_LOAD, 0, 1, 0, 3);
    // HALT retires, then sits halted with mem_ready toggling
    add(0, 0, 1, T_HALT, 0, T_LOAD, 1, 1, 0, 4);
    for (int s = 1; s < 5; s++) add(0, 0, 1, 0, 3'(s), T_HALT, 0, 1, 0, 4);
    for (int i = 0; i < 3; i++) add(0, 0, 1'(i + 1), 0, 0, T_HALT, 0, 0, 1, 5);
    add(0, 1, 1, 0, 0, T_HALT, 0, 0, 1, 5);
    // resume; start pulses in stages 2 and 3 must be ignored
    add(0, 0, 1, 5'd3, 0, T_HALT, 1, 1, 0, 5);
    add(0, 0, 1, 0, 1, 5'd3, 0, 1, 0, 5);
    add(0, 1, 1, 0, 2, 5'd3, 0, 1, 0, 5);
    add(0, 1, 1, 0, 3, 5'd3, 0, 1, 0, 5);
    add(0, 0, 1, 0, 4, 5'd3, 0, 1, 0, 5);
    // load, reset applied during the memory-stage stall
    add(0, 0, 1, T_LOAD, 0, 5'd3, 1, 1, 0, 6);
    add(0, 0, 1, 0, 1, T_LOAD, 0, 1, 0, 6);
    add(0, 0, 1, 0, 2, T_LOAD, 0, 1, 0, 6);
    add(1, 0, 0, 0, 3, T_LOAD, 1, 1, 0, 6);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

    // retired_count wrap: preload all-ones mid-instruction, retire one
    step(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0), 100);
    step(mk(0, 0, 1, 5'd3, 0, 0, 1, 1, 0, 0), 101);
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    for (int s = 1; s < 5; s++) step(mk(0, 0, 1, 0, 3'(s), 5'd3, 0, 1, 0, 32'hFFFF_FFFF), 101 + s);
    step(mk(0, 0, 0, 0, 0, 5'd3, 1, 1, 0, 0), 106);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
